legv8_decode_stage: RTL and testbench

Registered, parametrised LEGv8 instruction-decode stage between instruction fetch and register read. Classifies each 32-bit word into R, I, D, B, CB or IW format and extracts register indices, shamt and a sign-extended, width-parametrised immediate. Carries the fetch PC alongside the decoded fields. Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so `in_ready` is a registered signal, plus a synchronous pipeline flush.

---
 rtl/legv8_pkg.sv | 46 ++++
 rtl/legv8_field_extract.sv | 73 +++++++
 rtl/legv8_decode_stage.sv | 125 ++++++++++++
 tb/tb_legv8_decode_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 decode formats, opcode patterns and field positions.
package legv8_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_D   = 3'd2,
        FMT_B   = 3'd3,
        FMT_CB  = 3'd4,
        FMT_IW  = 3'd5,
        FMT_ILL = 3'd6
    } fmt_t;

    // Opcode patterns, each sized to the slice of [31:..] it is matched against
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    localparam int RD_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int SHAMT_LSB = 10;
    localparam int RM_LSB    = 16;
    localparam int OPC_LSB   = 21;

    typedef struct packed {
        fmt_t        fmt;
        logic [10:0] opcode;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [5:0]  shamt;
        logic        illegal;
    } dec_fields_t;

endpackage

// File: rtl/legv8_field_extract.sv
// rtl/legv8_field_extract.sv - combinational decode of one LEGv8 word into fields and immediate.
module legv8_field_extract
    import legv8_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output dec_fields_t     fields_o,
    output logic [XLEN-1:0] imm_o
);

    fmt_t fmt;

    always_comb begin
        fmt = FMT_ILL;
        if (instr_i[31:26] == OP_B)
            fmt = FMT_B;
        else if (instr_i[31:24] == OP_CBZ || instr_i[31:24] == OP_CBNZ)
            fmt = FMT_CB;
        else if (instr_i[31:23] == OP_MOVZ)
            fmt = FMT_IW;
        else if (instr_i[31:22] == OP_ADDI || instr_i[31:22] == OP_SUBI)
            fmt = FMT_I;
        else if (instr_i[31:21] == OP_LDUR || instr_i[31:21] == OP_STUR)
            fmt = FMT_D;
        else begin
            case (instr_i[31:21])
                OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL, OP_LSR: fmt = FMT_R;
                default: fmt = FMT_ILL;
            endcase
        end
    end

    // Fields a format does not use stay zero so downstream never sees stale bits
    always_comb begin
        fields_o         = '0;
        fields_o.fmt     = fmt;
        fields_o.opcode  = instr_i[OPC_LSB +: 11];
        fields_o.illegal = (fmt == FMT_ILL);
        imm_o            = '0;
        case (fmt)
            FMT_R: begin
                fields_o.rd    = instr_i[RD_LSB +: 5];
                fields_o.rn    = instr_i[RN_LSB +: 5];
                fields_o.rm    = instr_i[RM_LSB +: 5];
                fields_o.shamt = instr_i[SHAMT_LSB +: 6];
            end
            FMT_I: begin
                fields_o.rd = instr_i[RD_LSB +: 5];
                fields_o.rn = instr_i[RN_LSB +: 5];
                imm_o       = XLEN'(instr_i[21:10]);
            end
            FMT_D: begin
                fields_o.rd = instr_i[RD_LSB +: 5];
                fields_o.rn = instr_i[RN_LSB +: 5];
                imm_o       = XLEN'($signed(instr_i[20:12]));
            end
            FMT_B: begin
                imm_o = XLEN'($signed({instr_i[25:0], 2'b00}));
            end
            FMT_CB: begin
                fields_o.rd = instr_i[RD_LSB +: 5];
                imm_o       = XLEN'($signed({instr_i[23:5], 2'b00}));
            end
            FMT_IW: begin
                fields_o.rd = instr_i[RD_LSB +: 5];
                imm_o       = XLEN'(instr_i[20:5]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/legv8_decode_stage.sv
// rtl/legv8_decode_stage.sv - registered LEGv8 decode stage with main register plus one skid entry.
module legv8_decode_stage
    import legv8_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      fmt_out,
    output logic [10:0]     opcode_out,
    output logic [4:0]      rd_out,
    output logic [4:0]      rn_out,
    output logic [4:0]      rm_out,
    output logic [5:0]      shamt_out,
    output logic [XLEN-1:0] imm_out,
    output logic [PC_W-1:0] pc_out,
    output logic            illegal_out
);

    dec_fields_t     dec_fields;
    logic [XLEN-1:0] dec_imm;

    legv8_field_extract #(.XLEN(XLEN)) u_extract (
        .instr_i  (instruction),
        .fields_o (dec_fields),
        .imm_o    (dec_imm)
    );

    logic            main_valid_q, main_valid_d;
    dec_fields_t     main_fields_q, main_fields_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d;
    logic            skid_valid_q, skid_valid_d;
    dec_fields_t     skid_fields_q, skid_fields_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic            in_ready_q;

    logic accept;
    logic main_load;

    assign accept    = in_valid && in_ready_q;
    assign main_load = !main_valid_q || out_ready;

    always_comb begin
        main_valid_d  = main_valid_q;
        main_fields_d = main_fields_q;
        main_imm_d    = main_imm_q;
        main_pc_d     = main_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_fields_d = skid_fields_q;
        skid_imm_d    = skid_imm_q;
        skid_pc_d     = skid_pc_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_load) begin
            // Skid is older than anything on the input, so it drains first
            if (skid_valid_q) begin
                main_valid_d  = 1'b1;
                main_fields_d = skid_fields_q;
                main_imm_d    = skid_imm_q;
                main_pc_d     = skid_pc_q;
                skid_valid_d  = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_fields_d = dec_fields;
                    main_imm_d    = dec_imm;
                    main_pc_d     = pc_in;
                end
            end
        end else if (accept) begin
            skid_valid_d  = 1'b1;
            skid_fields_d = dec_fields;
            skid_imm_d    = dec_imm;
            skid_pc_d     = pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q  <= 1'b0;
            main_fields_q <= '0;
            main_imm_q    <= '0;
            main_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
            skid_fields_q <= '0;
            skid_imm_q    <= '0;
            skid_pc_q     <= '0;
            in_ready_q    <= 1'b1;
        end else begin
            main_valid_q  <= main_valid_d;
            main_fields_q <= main_fields_d;
            main_imm_q    <= main_imm_d;
            main_pc_q     <= main_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_fields_q <= skid_fields_d;
            skid_imm_q    <= skid_imm_d;
            skid_pc_q     <= skid_pc_d;
            in_ready_q    <= !skid_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign fmt_out     = main_fields_q.fmt;
    assign opcode_out  = main_fields_q.opcode;
    assign rd_out      = main_fields_q.rd;
    assign rn_out      = main_fields_q.rn;
    assign rm_out      = main_fields_q.rm;
    assign shamt_out   = main_fields_q.shamt;
    assign illegal_out = main_fields_q.illegal;
    assign imm_out     = main_imm_q;
    assign pc_out      = main_pc_q;

endmodule

// File: tb/tb_legv8_decode_stage.sv
// tb/tb_legv8_decode_stage.sv - self-checking bench for legv8_decode_stage at XLEN=64 and XLEN=32.
module tb_legv8_decode_stage;
    import legv8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [63:0] pc_in = 64'h0;
    logic [63:0] pc_ctr = 64'h1000;

    logic        ir64, ov64, ill64, ir32, ov32, ill32;
    logic [2:0]  fmt64, fmt32;
    logic [10:0] op64, op32;
    logic [4:0]  rd64, rn64, rm64, rd32, rn32, rm32;
    logic [5:0]  sh64, sh32;
    logic [63:0] imm64, pc64, pc32;
    logic [31:0] imm32;

    legv8_decode_stage #(.XLEN(64), .PC_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .instruction(instruction), .pc_in(pc_in), .out_valid(ov64), .out_ready(out_ready),
        .fmt_out(fmt64), .opcode_out(op64), .rd_out(rd64), .rn_out(rn64), .rm_out(rm64),
        .shamt_out(sh64), .imm_out(imm64), .pc_out(pc64), .illegal_out(ill64));

    legv8_decode_stage #(.XLEN(32), .PC_W(64)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .instruction(instruction), .pc_in(pc_in), .out_valid(ov32), .out_ready(out_ready),
        .fmt_out(fmt32), .opcode_out(op32), .rd_out(rd32), .rn_out(rn32), .rm_out(rm32),
        .shamt_out(sh32), .imm_out(imm32), .pc_out(pc32), .illegal_out(ill32));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [10:0] op;
        logic [4:0]  rd, rn, rm;
        logic [5:0]  sh;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        logic [10:0] op;
        op = w[31:21];
        e.op = op; e.pc = pc; e.rd = 5'd0; e.rn = 5'd0; e.rm = 5'd0; e.sh = 6'd0;
        e.imm = 64'd0; e.ill = 1'b0; e.fmt = FMT_ILL;
        if (op[10:5] == 6'h05) begin
            e.fmt = FMT_B;  e.imm = longint'($signed(w[25:0])) * 4;
        end else if (op[10:3] inside {8'hB4, 8'hB5}) begin
            e.fmt = FMT_CB; e.rd = w[4:0]; e.imm = longint'($signed(w[23:5])) * 4;
        end else if (op[10:2] == 9'h1A5) begin
            e.fmt = FMT_IW; e.rd = w[4:0]; e.imm = 64'(w[20:5]);
        end else if (op[10:1] inside {10'h244, 10'h344}) begin
            e.fmt = FMT_I;  e.rd = w[4:0]; e.rn = w[9:5]; e.imm = 64'(w[21:10]);
        end else if (op inside {11'h7C2, 11'h7C0}) begin
            e.fmt = FMT_D;  e.rd = w[4:0]; e.rn = w[9:5]; e.imm = longint'($signed(w[20:12]));
        end else if (op inside {11'h458, 11'h658, 11'h450, 11'h550, 11'h69B, 11'h69A}) begin
            e.fmt = FMT_R;  e.rd = w[4:0]; e.rn = w[9:5]; e.rm = w[20:16]; e.sh = w[15:10];
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Occupancy model: up to two words held, one consumed per ready cycle
    always @(posedge clk or negedge rst_n) begin
        int n;
        if (!rst_n) q.delete();
        else begin
            n = q.size();
            if (n > 0 && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && n < 2) q.push_back(model(instruction, pc_in));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ov64", 64'(ov64), 64'(q.size() > 0));
            chk("ir64", 64'(ir64), 64'(q.size() < 2));
            chk("ov32", 64'(ov32), 64'(q.size() > 0));
            chk("ir32", 64'(ir32), 64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("fmt64", 64'(fmt64), 64'(q[0].fmt));
                chk("op64", 64'(op64), 64'(q[0].op));
                chk("rd64", 64'(rd64), 64'(q[0].rd));
                chk("rn64", 64'(rn64), 64'(q[0].rn));
                chk("rm64", 64'(rm64), 64'(q[0].rm));
                chk("sh64", 64'(sh64), 64'(q[0].sh));
                chk("imm64", imm64, q[0].imm);
                chk("pc64", pc64, q[0].pc);
                chk("ill64", 64'(ill64), 64'(q[0].ill));
                chk("fmt32", 64'(fmt32), 64'(q[0].fmt));
                chk("rd32", 64'(rd32), 64'(q[0].rd));
                chk("imm32", 64'(imm32), 64'(q[0].imm[31:0]));
                chk("pc32", pc32, q[0].pc);
                chk("ill32", 64'(ill32), 64'(q[0].ill));
            end
        end
    end

    task automatic cyc(input logic iv, input logic [31:0] w, input logic orr, input logic fl);
        @(posedge clk);
        #2;
        in_valid = iv; instruction = w; out_ready = orr; flush = fl;
        pc_in = pc_ctr; pc_ctr += 64'd4;
    endtask

    localparam logic [31:0] W_LDUR = 32'hF85F8041;
    localparam logic [31:0] W_ADDI = 32'h913FFC83;
    localparam logic [31:0] W_B    = 32'h17FFFFFF;
    localparam logic [31:0] W_CBZ  = 32'hB4000045;
    localparam logic [31:0] W_ADD  = 32'h8B030041;
    localparam logic [31:0] W_SUB  = 32'hCB0600A4;
    localparam logic [31:0] W_LSL  = 32'hD360FD07;
    localparam logic [31:0] W_MOVZ = 32'hD297DDE9;
    localparam logic [31:0] W_ADDR = 32'h8B030040;

    initial begin
        logic [31:0] mix [6];
        mix = '{32'hF81F0062, 32'hD10010A5, 32'h8A0200E1, 32'hAA0300C4, 32'hD340FD07, 32'hB50000A9};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_ov", 64'(ov64), 64'd0);
        chk("rst_ir", 64'(ir64), 64'd1);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_pc", pc64, 64'd0);

        cyc(1, W_LDUR, 1, 0); cyc(0, 0, 1, 0);
        chk("ldur_fmt", 64'(fmt64), 64'(FMT_D));
        chk("ldur_rd", 64'(rd64), 64'd1);
        chk("ldur_rn", 64'(rn64), 64'd2);
        chk("ldur_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ldur_imm32", 64'(imm32), 64'hFFFF_FFF8);

        cyc(1, W_ADDI, 1, 0); cyc(0, 0, 1, 0);
        chk("addi_fmt", 64'(fmt64), 64'(FMT_I));
        chk("addi_imm", imm64, 64'd4095);
        chk("addi_rd", 64'(rd64), 64'd3);

        cyc(1, W_B, 1, 0); cyc(0, 0, 1, 0);
        chk("b_fmt", 64'(fmt64), 64'(FMT_B));
        chk("b_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("b_imm32", 64'(imm32), 64'hFFFF_FFFC);

        cyc(1, W_CBZ, 1, 0); cyc(0, 0, 1, 0);
        chk("cbz_fmt", 64'(fmt64), 64'(FMT_CB));
        chk("cbz_rd", 64'(rd64), 64'd5);
        chk("cbz_imm", imm64, 64'd8);

        cyc(1, W_ADD, 1, 0);
        cyc(1, W_SUB, 1, 0);
        chk("b2b_add_rd", 64'(rd64), 64'd1);
        cyc(1, W_LSL, 1, 0);
        chk("b2b_sub_rd", 64'(rd64), 64'd4);
        cyc(0, 0, 1, 0);
        chk("b2b_lsl_rd", 64'(rd64), 64'd7);
        chk("b2b_lsl_sh", 64'(sh64), 64'd63);
        chk("b2b_valid", 64'(ov64), 64'd1);

        foreach (mix[i]) cyc(1, mix[i], 1, 0);
        cyc(0, 0, 1, 0);

        cyc(1, W_ADDR | 32'd10, 0, 0);
        cyc(1, W_ADDR | 32'd11, 0, 0);
        chk("stall_ir_e1", 64'(ir64), 64'd1);
        chk("stall_rd_e1", 64'(rd64), 64'd10);
        cyc(1, W_ADDR | 32'd12, 0, 0);
        chk("stall_ir_e2", 64'(ir64), 64'd0);
        cyc(1, W_ADDR | 32'd13, 0, 0);
        chk("stall_ir_e3", 64'(ir64), 64'd0);
        chk("stall_hold", 64'(rd64), 64'd10);
        cyc(0, 0, 1, 0);
        chk("stall_ir_e4", 64'(ir64), 64'd0);
        cyc(0, 0, 1, 0);
        chk("release_rd", 64'(rd64), 64'd11);
        chk("release_ir", 64'(ir64), 64'd1);
        cyc(0, 0, 1, 0);
        chk("release_empty", 64'(ov64), 64'd0);

        cyc(1, W_ADDR | 32'd20, 0, 0);
        cyc(1, W_ADDR | 32'd21, 0, 0);
        cyc(1, W_ADDR | 32'd22, 0, 1);
        cyc(0, 0, 0, 0);
        chk("flush_ov", 64'(ov64), 64'd0);
        chk("flush_ir", 64'(ir64), 64'd1);
        cyc(1, W_ADDR | 32'd23, 1, 0);
        cyc(1, W_ADDR | 32'd24, 1, 1);
        cyc(0, 0, 1, 0);
        chk("flush2_ov", 64'(ov64), 64'd0);
        cyc(1, W_ADDR | 32'd25, 1, 0);
        cyc(0, 0, 1, 0);
        chk("after_flush_rd", 64'(rd64), 64'd25);

        cyc(1, 32'h0000_0000, 1, 0);
        cyc(1, 32'hFFFF_FFFF, 1, 0);
        chk("ill0_flag", 64'(ill64), 64'd1);
        chk("ill0_fmt", 64'(fmt64), 64'(FMT_ILL));
        cyc(1, W_ADDR | 32'd26, 1, 0);
        chk("ill1_flag", 64'(ill64), 64'd1);
        chk("ill1_imm", imm64, 64'd0);
        cyc(0, 0, 1, 0);
        chk("ill_flow_rd", 64'(rd64), 64'd26);
        chk("ill_flow_ill", 64'(ill64), 64'd0);

        cyc(1, W_ADDR | 32'd27, 0, 0);
        cyc(1, W_ADDR | 32'd28, 0, 0);
        cyc(0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ov64", 64'(ov64), 64'd0);
        chk("arst_ov32", 64'(ov32), 64'd0);
        chk("arst_ir", 64'(ir64), 64'd1);
        chk("arst_rd", 64'(rd64), 64'd0);
        chk("arst_pc", pc64, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1, W_MOVZ, 1, 0); cyc(0, 0, 1, 0);
        chk("movz_fmt", 64'(fmt64), 64'(FMT_IW));
        chk("movz_imm", imm64, 64'hBEEF);
        chk("movz_rd", 64'(rd64), 64'd9);

        repeat (3) cyc(0, 0, 1, 0);
        chk("drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
